rv32i_trace_buffer: RTL and testbench
=====================================

# rv32i_trace_buffer

Parametrised write-back trace capture for the RV32I core, replacing ad-hoc register monitoring in simulation with a synthesizable block. Observes the core's register-file write port, keeps a live shadow copy of a configurable window of architectural registers, and logs each qualifying write as a (PC, rd, data) entry into a DEPTH-entry buffer. The buffer is drained through a valid/ready port and supports both circular (overwrite-oldest) and stop-when-full capture modes.

## Interface
Parameters:
- XLEN, 32, data and PC width.
- DEPTH, 16, trace entries; power of two, 2..256.
- NWATCH, 5, number of consecutive registers watched.
- WATCH_BASE, 5, first watched register index; WATCH_BASE ≥ 1 and WATCH_BASE+NWATCH ≤ 32.

Ports:
- Clk  in  1  core clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Arm  in  1  capture enable; sampled every cycle.
- ModeStop  in  1  0 = circular overwrite, 1 = stop when full.
- Clear  in  1  synchronous flush of buffer and Overflow; shadow registers unaffected.
- WbEn  in  1  register-file write enable from the core.
- WbRd  in  5  write destination index.
- WbData  in  XLEN  write data.
- WbPC  in  XLEN  PC of the retiring instruction.
- WatchVal  out  NWATCH*XLEN  shadow values; slice i = register WATCH_BASE+i.
- RdValid  out  1  head entry available.
- RdReady  in  1  consumer accepts head entry.
- RdPC  out  XLEN  head entry PC.
- RdIdx  out  5  head entry rd.
- RdData  out  XLEN  head entry data.
- RdTime  out  16  head entry timestamp (see Configuration).
- Count  out  clog2(DEPTH)+1  entries held.
- Full  out  1  Count == DEPTH.
- Overflow  out  1  sticky: an entry was dropped or overwritten.

## Operation
- Hit = WbEn && WbRd ≥ WATCH_BASE && WbRd < WATCH_BASE+NWATCH (x0 never hits).
- Shadow: on Hit, slice WbRd−WATCH_BASE ← WbData, regardless of Arm.
- Push = Hit && Arm && !Clear. Pop = RdValid && RdReady && !Clear.
- Storage: DEPTH-entry RAM, write pointer, read pointer, count; pointers wrap modulo DEPTH.
- First-word-fall-through: Rd* show the entry at the read pointer whenever RdValid = 1; Rd* are don't-care when RdValid = 0.
- Push, not full: write entry, advance write pointer, Count+1.
- Push + Pop, any occupancy: both execute, Count unchanged, no drop, Overflow unchanged.
- Push when Full, no Pop, ModeStop=0: write over oldest, advance both pointers, Count stays DEPTH, Overflow ← 1.
- Push when Full, no Pop, ModeStop=1: entry discarded, state unchanged, Overflow ← 1.
- Pop when empty: impossible by definition (RdValid=0).
- Clear: pointers and Count ← 0, Overflow ← 0; a simultaneous Hit still updates the shadow but is not logged.
- ModeStop and Arm may change at any cycle; take effect on the same edge.

## Timing
- Reset values: WatchVal all 0, Count 0, RdValid 0, Full 0, Overflow 0, pointers 0; RAM contents not reset.
- Write-to-read latency: entry pushed at edge N makes RdValid = 1 after edge N (visible in cycle N+1).
- Shadow latency: WatchVal updated after the same edge as the write.
- RdValid, Full, Count, Overflow are registered-state-derived; no combinational path from WbEn to RdValid.
- RdReady may depend combinationally on RdValid; Rd* must not depend on RdReady.
- Rst overrides Clear, Push and Pop; reset mid-drain discards all entries.

## Configuration
- TRACE_TIMESTAMP_EN defined: free-running 16-bit cycle counter, reset to 0, wraps at 0xFFFF; counter value at push edge stored with each entry and presented on RdTime.
- Not defined: no counter or timestamp storage; RdTime tied to 0. All other behaviour identical.

## Test plan
- Reset then write x6 = 0x1234 at PC 0x10, Arm=1 -> WatchVal slice 1 = 0x1234, RdValid=1 next cycle, RdPC=0x10, RdIdx=6, RdData=0x1234, Count=1.
- Writes to x0, x4, x10 with Arm=1 -> no entry, Count=0, WatchVal unchanged.
- DEPTH=16, ModeStop=0, 20 hits with data 1..20, RdReady=0 -> Count=16, Overflow=1; drain returns data 5..20 in order.
- ModeStop=1, same 20 hits -> Count=16, Overflow=1; drain returns 1..16; afterwards RdValid=0, Full=0.
- Full buffer, RdReady=1 and Hit in the same cycle, 10 consecutive cycles -> Count stays 16, Overflow stays 0, popped data strictly in write order.
- With TRACE_TIMESTAMP_EN, hits at cycles 3 and 7 after reset release -> RdTime difference between entries = 4; Clear during a hit -> Count=0, Overflow=0, shadow updated.

Source files
------------

// File: rtl/rv32i_trace_buffer.sv
// rv32i_trace_buffer: write-back trace capture for the RV32I core.
// Watches the register-file write port. It keeps shadow copies of NWATCH
// consecutive registers, starting at WATCH_BASE. It also logs each qualifying
// write as a (PC, rd, data) entry into a DEPTH-entry first-word-fall-through
// buffer, which is drained through a valid/ready port.
// Optional feature: define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp
// with each entry on RdTime_o. When it is not defined, RdTime_o is 0.
// Ports:
//   Clk_i, Rst_i              clock, synchronous active-high reset
//   Arm_i, ModeStop_i         capture enable, 0 = circular / 1 = stop when full
//   Clear_i                   flush buffer and Overflow (shadow untouched)
//   WbEn_i/WbRd_i/WbData_i/WbPC_i   core write-back port
//   WatchVal_o                shadow values, slice i = x(WATCH_BASE+i)
//   RdValid_o/RdReady_i       drain handshake
//   RdPC_o/RdIdx_o/RdData_o/RdTime_o  head entry
//   Count_o, Full_o, Overflow_o       occupancy and sticky drop flag
module rv32i_trace_buffer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NWATCH     = 5,
    parameter int unsigned WATCH_BASE = 5
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic                       Arm_i,
    input  logic                       ModeStop_i,
    input  logic                       Clear_i,
    input  logic                       WbEn_i,
    input  logic [4:0]                 WbRd_i,
    input  logic [XLEN-1:0]            WbData_i,
    input  logic [XLEN-1:0]            WbPC_i,
    output logic [NWATCH*XLEN-1:0]     WatchVal_o,
    output logic                       RdValid_o,
    input  logic                       RdReady_i,
    output logic [XLEN-1:0]            RdPC_o,
    output logic [4:0]                 RdIdx_o,
    output logic [XLEN-1:0]            RdData_o,
    output logic [15:0]                RdTime_o,
    output logic [$clog2(DEPTH):0]     Count_o,
    output logic                       Full_o,
    output logic                       Overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] watch_q [NWATCH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [4:0]      rd_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          mem_we;
    logic          hit, push, pop, full;
    logic [5:0]    rd_ext;

    // Window hit; the extra bit covers WATCH_BASE+NWATCH == 32.
    assign rd_ext = {1'b0, WbRd_i};
    assign hit    = WbEn_i && (rd_ext >= 6'(WATCH_BASE)) && (rd_ext < 6'(WATCH_BASE + NWATCH));
    assign full   = (count_q == CW'(DEPTH));
    assign push   = hit && Arm_i && !Clear_i;
    assign pop    = RdValid_o && RdReady_i && !Clear_i;

    // Shadow register window, updated on every hit regardless of Arm/Clear.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            for (int i = 0; i < int'(NWATCH); i++) watch_q[i] <= '0;
        end else if (hit) begin
            for (int i = 0; i < int'(NWATCH); i++)
                if (WbRd_i == 5'(WATCH_BASE + 32'(i))) watch_q[i] <= WbData_i;
        end
    end

    for (genvar g = 0; g < int'(NWATCH); g++) begin : g_watch
        assign WatchVal_o[g*XLEN +: XLEN] = watch_q[g];
    end

    // Buffer bookkeeping: pointers, occupancy, sticky overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        if (Clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (push && pop) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + AW'(1);
            rptr_d = rptr_q + AW'(1);
        end else if (push && !full) begin
            mem_we  = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            count_d = count_q + CW'(1);
        end else if (push) begin
            ovf_d = 1'b1;
            // Circular mode overwrites the oldest entry; stop mode drops the new one.
            if (!ModeStop_i) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + AW'(1);
                rptr_d = rptr_q + AW'(1);
            end
        end else if (pop) begin
            rptr_d  = rptr_q + AW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge Clk_i) begin
        if (mem_we) begin
            pc_mem[wptr_q]  <= WbPC_i;
            rd_mem[wptr_q]  <= WbRd_i;
            dat_mem[wptr_q] <= WbData_i;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    // Free-running cycle stamp, wraps naturally at 0xFFFF.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge Clk_i) begin
        if (mem_we) ts_mem[wptr_q] <= ts_q;
    end

    assign RdTime_o = ts_mem[rptr_q];
`else
    assign RdTime_o = 16'h0000;
`endif

    assign RdValid_o  = (count_q != '0);
    assign RdPC_o     = pc_mem[rptr_q];
    assign RdIdx_o    = rd_mem[rptr_q];
    assign RdData_o   = dat_mem[rptr_q];
    assign Count_o    = count_q;
    assign Full_o     = full;
    assign Overflow_o = ovf_q;
endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// Scoreboard bench for rv32i_trace_buffer (default parameters).
module tb_rv32i_trace_buffer;
    logic        clk = 1'b0;
    logic        Rst, Arm, ModeStop, Clear, WbEn, RdReady;
    logic [4:0]  WbRd;
    logic [31:0] WbData, WbPC;
    logic [159:0] WatchVal;
    logic        RdValid, Full, Overflow;
    logic [31:0] RdPC, RdData;
    logic [4:0]  RdIdx;
    logic [15:0] RdTime;
    logic [4:0]  Count;

    always #5 clk = ~clk;

    rv32i_trace_buffer dut (
        .Clk_i(clk), .Rst_i(Rst), .Arm_i(Arm), .ModeStop_i(ModeStop), .Clear_i(Clear),
        .WbEn_i(WbEn), .WbRd_i(WbRd), .WbData_i(WbData), .WbPC_i(WbPC),
        .WatchVal_o(WatchVal), .RdValid_o(RdValid), .RdReady_i(RdReady),
        .RdPC_o(RdPC), .RdIdx_o(RdIdx), .RdData_o(RdData), .RdTime_o(RdTime),
        .Count_o(Count), .Full_o(Full), .Overflow_o(Overflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    logic        m_ovf;
    logic [31:0] m_watch [5];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] t0, t1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, score the pop before the edge, check state after it.
    task automatic step(input logic en, input logic [4:0] rd, input logic [31:0] data,
                        input logic [31:0] pc, input logic rdy, input logic clr);
        ent_t e;
        logic mpop, hit;
        WbEn = en; WbRd = rd; WbData = data; WbPC = pc; RdReady = rdy; Clear = clr;
        #1;
        if (!Rst) check("rd_valid", 64'(RdValid), 64'(sb.size() > 0));
        mpop = (sb.size() > 0) && rdy && !clr && !Rst;
        if (mpop) begin
            check("rd_pc", 64'(RdPC), 64'(sb[0].pc));
            check("rd_idx", 64'(RdIdx), 64'(sb[0].rd));
            check("rd_data", 64'(RdData), 64'(sb[0].data));
            void'(sb.pop_front());
        end
        hit = en && (rd >= 5'd5) && (rd < 5'd10);
        if (Rst) begin
            sb.delete();
            m_ovf = 1'b0;
            for (int i = 0; i < 5; i++) m_watch[i] = '0;
        end else begin
            if (hit) m_watch[int'(rd) - 5] = data;
            if (clr) begin
                sb.delete();
                m_ovf = 1'b0;
            end else if (hit && Arm) begin
                e.pc = pc; e.rd = rd; e.data = data;
                if (sb.size() < 16) sb.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (!ModeStop) begin
                        void'(sb.pop_front());
                        sb.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("count", 64'(Count), 64'(sb.size()));
        check("full", 64'(Full), 64'(sb.size() == 16));
        check("overflow", 64'(Overflow), 64'(m_ovf));
        for (int i = 0; i < 5; i++) check("watch", 64'(WatchVal[i*32 +: 32]), 64'(m_watch[i]));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic hits20;
        for (int i = 1; i <= 20; i++)
            step(1'b1, 5'(5 + (i % 5)), 32'(i), 32'(32'h100 + 4 * i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) idle(1'b1);
    endtask

    initial begin
        Rst = 1'b1; Arm = 1'b1; ModeStop = 1'b0; Clear = 1'b0;
        WbEn = 1'b0; WbRd = '0; WbData = '0; WbPC = '0; RdReady = 1'b0;
        for (int i = 0; i < 5; i++) m_watch[i] = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        idle(1'b0);
        idle(1'b0);
        Rst = 1'b0;
        check("reset_count", 64'(Count), 64'd0);
        check("reset_valid", 64'(RdValid), 64'd0);
        check("reset_watch", 64'(WatchVal == '0), 64'd1);

        // Single write x6 = 0x1234 at PC 0x10.
        step(1'b1, 5'd6, 32'h1234, 32'h10, 1'b0, 1'b0);
        check("x6_slice", 64'(WatchVal[63:32]), 64'h1234);
        check("x6_valid", 64'(RdValid), 64'd1);
        check("x6_data", 64'(RdData), 64'h1234);
        drain(1);

        // Writes outside the window.
        step(1'b1, 5'd0, 32'hdead, 32'h20, 1'b0, 1'b0);
        step(1'b1, 5'd4, 32'hbeef, 32'h24, 1'b0, 1'b0);
        step(1'b1, 5'd10, 32'hcafe, 32'h28, 1'b0, 1'b0);
        check("miss_count", 64'(Count), 64'd0);

        // Circular mode: the four oldest entries are overwritten.
        hits20();
        check("circ_head", 64'(RdData), 64'd5);
        check("circ_ovf", 64'(Overflow), 64'd1);
        drain(17);

        // Stop mode: the four newest entries are dropped.
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        ModeStop = 1'b1;
        hits20();
        check("stop_head", 64'(RdData), 64'd1);
        drain(17);
        check("stop_empty", 64'(RdValid), 64'd0);

        // Full buffer with a simultaneous push and pop each cycle.
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 5'd8, 32'(100 + i), 32'(32'h200 + 4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'd9, 32'(200 + i), 32'(32'h300 + 4 * i), 1'b1, 1'b0);
        check("pp_full", 64'(Full), 64'd1);
        check("pp_ovf", 64'(Overflow), 64'd0);
        drain(16);

        // Clear with a simultaneous hit.
        ModeStop = 1'b0;
        step(1'b1, 5'd5, 32'h11, 32'h400, 1'b0, 1'b0);
        step(1'b1, 5'd7, 32'h77, 32'h404, 1'b0, 1'b1);
        check("clr_slice", 64'(WatchVal[95:64]), 64'h77);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd6, 32'(i), 32'(i), 1'b0, 1'b0);
        idle(1'b1);
        Rst = 1'b1;
        idle(1'b1);
        Rst = 1'b0;
        check("rst_mid_valid", 64'(RdValid), 64'd0);

        // Two hits four cycles apart; with timestamps the stamps differ by 4.
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 5'd5, 32'ha, 32'h500, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 5'd5, 32'hb, 32'h504, 1'b0, 1'b0);
        t0 = RdTime;
        idle(1'b1);
        t1 = RdTime;
`ifdef TRACE_TIMESTAMP_EN
        check("ts_delta", 64'(16'(t1 - t0)), 64'd4);
`else
        check("ts_zero0", 64'(t0), 64'd0);
        check("ts_zero1", 64'(t1), 64'd0);
`endif
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
